// File: rtl/dmux8way16_buf_if.sv
// Bus bundle for dmux8way16_buf: producer handshake, destination select,
// the eight registered channels, their valid/ack pairs and the accept counter.
interface dmux8way16_buf_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic             auto;
  logic [2:0]       ptr;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [7:0]       valid;
  logic [7:0]       ack;
  logic [15:0]      count;

  modport master (
    output in, in_valid, sel, auto, ack,
    input  in_ready, ptr, a, b, c, d, e, f, g, h, valid, count
  );

  modport slave (
    input  in, in_valid, sel, auto, ack,
    output in_ready, ptr, a, b, c, d, e, f, g, h, valid, count
  );
endinterface

// File: rtl/dmux8way16_buf.sv
// Registered 1-to-8 demultiplexer: each accepted word lands in one of eight
// channel registers chosen by sel or by a rotating auto pointer.
module dmux8way16_buf #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   dmux8way16_buf_if.slave bus
);

   logic [WIDTH-1:0] data_q [8];
   logic [7:0]       valid_q;
   logic [7:0]       valid_nxt;
   logic [2:0]       ptr_q;
   logic [15:0]      count_q;
   logic [2:0]       dst;
   logic             ready;
   logic             accept;

   // A channel may take a new word if it is empty or being drained this cycle.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      dst       = bus.auto ? ptr_q : bus.sel;
      ready     = ~valid_q[dst] | bus.ack[dst];
      accept    = bus.in_valid & ready;
      valid_nxt = valid_q & ~bus.ack;
      if (accept) valid_nxt[dst] = 1'b1;
   end

   // NOTE: the channel array is reset because its contents drive outputs that must read 0 in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 8; k++) data_q[k] <= '0;
         valid_q <= 8'h00;
         ptr_q   <= 3'd0;
         count_q <= 16'd0;
      end else begin
         valid_q <= valid_nxt;
         if (accept) begin
            data_q[dst] <= bus.in;
            count_q     <= count_q + 16'd1;
            if (bus.auto) ptr_q <= ptr_q + 3'd1;
         end
      end
   end

   assign bus.in_ready = ready;
   assign bus.ptr      = ptr_q;
   assign bus.valid    = valid_q;
   assign bus.count    = count_q;
   assign bus.a        = data_q[0];
   assign bus.b        = data_q[1];
   assign bus.c        = data_q[2];
   assign bus.d        = data_q[3];
   assign bus.e        = data_q[4];
   assign bus.f        = data_q[5];
   assign bus.g        = data_q[6];
   assign bus.h        = data_q[7];

endmodule

// File: doc/dmux8way16_buf.md
DMUX8WAY16_BUF -- requirements
Module: dmux8way16_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width of the input and of each of the eight channel registers.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in, input, WIDTH, the word to be distributed.
REQ-005 SHALL have port in_valid, input, 1, high when in holds a word to deliver.
REQ-006 SHALL have port in_ready, output, 1, high when the word on in is accepted this cycle.
REQ-007 SHALL have port sel, input, 3, the destination channel when auto=0 (0=a ... 7=h).
REQ-008 SHALL have port auto, input, 1, which selects the internal pointer ptr as the destination instead of sel.
REQ-009 SHALL have port ptr, output, 3, the current auto-mode destination pointer.
REQ-010 SHALL have ports a, b, c, d, e, f, g, h, each output, WIDTH, the registered channel data.
REQ-011 SHALL have port valid, output, 8, where bit k is high when channel k holds an undelivered word (bit 0=a ... bit 7=h).
REQ-012 SHALL have port ack, input, 8, where bit k high means the consumer takes channel k this cycle.
REQ-013 SHALL have port count, output, 16, the number of words accepted since reset, wrapping modulo 2^16.

Function
REQ-014 SHALL use destination dst = ptr when auto=1 and dst = sel otherwise, evaluated combinationally.
REQ-015 SHALL drive in_ready = !valid[dst] | ack[dst], combinationally, with no dependence on in_valid.
REQ-016 SHALL accept a word when in_valid & in_ready are both high at a rising edge.
REQ-017 SHALL, on accept, load channel dst register with in and set valid[dst]; both are visible the cycle after the edge (latency 1).
REQ-018 SHALL, on accept with auto=1, set ptr to ptr+1, wrapping 7 -> 0; ptr SHALL hold when auto=0 or when no word is accepted.
REQ-019 SHALL, on accept, set count to count+1, wrapping 0xFFFF -> 0x0000.
REQ-020 SHALL clear valid[k] when ack[k] & valid[k] are high and channel k is not being written in the same cycle.
REQ-021 SHALL, when channel k is simultaneously acked and written, keep valid[k]=1 and replace the data with in (pass-through, no bubble).
REQ-022 SHALL ignore ack[k] when valid[k]=0, leaving both data and valid unchanged.
REQ-023 SHALL hold each channel's data register unchanged unless that channel is written; an ack SHALL NOT clear the data.
REQ-024 SHALL NOT accept a word when in_valid=0, even if in_ready=1, and SHALL leave all state unchanged in that case except for ack-driven clears.
REQ-025 SHALL, when valid[dst]=1 and ack[dst]=0, hold in_ready low and stall without dropping or overwriting any word.
REQ-026 SHALL let a toggle of auto or a change of sel take effect in the same cycle, because dst is combinational.
REQ-027 SHALL contain no combinational path from in to any of a through h.

Reset
REQ-028 SHALL, while reset=1 and independent of clk, force a through h to 0, valid to 8'h00, ptr to 0 and count to 0.
REQ-029 SHALL accept no word while reset=1.
REQ-030 SHALL, on reset asserted mid-operation, discard all pending channel words; the first accept after release SHALL use ptr=0 in auto mode.

Verification
REQ-031 SHALL cover manual fill: auto=0; write 16'h1111..16'h8888 to sel=0..7 with ack=0 -> valid=8'hFF, a=16'h1111 ... h=16'h8888, count=8.
REQ-032 SHALL cover a full-channel stall: with valid[3]=1 and ack=0, drive in_valid=1, sel=3, in=16'hBEEF -> in_ready=0 and d unchanged; then assert ack[3] -> in_ready=1 and d=16'hBEEF the next cycle with valid[3] still 1.
REQ-033 SHALL cover auto wrap: auto=1 from ptr=0 with ack=8'hFF; send 9 words 0..8 -> a..h receive 0..7, then a receives 8; ptr=1, count=9.
REQ-034 SHALL cover ack only: valid=8'h05 and ack=8'h0F with in_valid=0 -> valid=8'h00 next cycle; a and c data are unchanged.
REQ-035 SHALL cover async reset: assert reset between clock edges after filling channels -> outputs, valid, ptr and count are 0 before the next edge.
